// File: rtl/frame_buffer_ctrl.sv
// Frame-buffer sequencer: clear engine + draw share the RAM write port; scan reads return 2 cycles after handshake.
// Draw/scan are held off (ready low) for the L cycles of a clear; collisions use a write-data bypass.
module frame_buffer_ctrl #(
  parameter int W = 8,
  parameter int L = 32,
  parameter logic [W-1:0] CLEAR_VALUE = '0,
  localparam int AW = (L > 1) ? $clog2(L) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output logic          busy,
  input  logic          draw_valid,
  output logic          draw_ready,
  input  logic [AW-1:0] draw_addr,
  input  logic [W-1:0]  draw_data,
  input  logic          scan_valid,
  output logic          scan_ready,
  input  logic [AW-1:0] scan_addr,
  output logic [W-1:0]  scan_data,
  output logic          scan_data_valid,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [W-1:0]  ram_rd_data,
  output logic          ram_wr_ena,
  output logic [AW-1:0] ram_wr_addr,
  output logic [W-1:0]  ram_wr_data
);

  localparam logic ST_CLEARING = 1'b0;
  localparam logic ST_ACTIVE   = 1'b1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(L - 1);

  logic          state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          wr_ena_q, wr_ena_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [W-1:0]  wr_data_q, wr_data_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_vld1_q, rd_vld2_q;
  logic          byp_hit_q;
  logic [W-1:0]  byp_data_q;
  logic [W-1:0]  scan_hold_q;
  logic [W-1:0]  scan_result;
  logic          scan_fire;

  assign busy        = (state_q == ST_CLEARING);
  assign draw_ready  = (state_q == ST_ACTIVE);
  assign scan_ready  = (state_q == ST_ACTIVE);
  assign scan_fire   = scan_valid & scan_ready;

  assign ram_wr_ena  = wr_ena_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign ram_rd_addr = rd_addr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_ena_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    if (state_q == ST_CLEARING) begin
      wr_ena_d  = 1'b1;
      wr_addr_d = cnt_q;
      wr_data_d = CLEAR_VALUE;
      // Stop on L-1 rather than wrapping so non-power-of-two depths never touch unused addresses.
      if (cnt_q == LAST_ADDR) begin
        state_d = ST_ACTIVE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (draw_valid) begin
        wr_ena_d  = 1'b1;
        wr_addr_d = draw_addr;
        wr_data_d = draw_data;
      end
      if (scan_valid) begin
        rd_addr_d = scan_addr;
      end
      if (clear_req) begin
        state_d = ST_CLEARING;
        cnt_d   = '0;
      end
    end
  end

  // RAM returns old data when read and write hit the same entry on one edge, so remember the write.
  assign scan_result     = byp_hit_q ? byp_data_q : ram_rd_data;
  assign scan_data_valid = rd_vld2_q;
  assign scan_data       = rd_vld2_q ? scan_result : scan_hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_CLEARING;
      cnt_q       <= '0;
      wr_ena_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      rd_addr_q   <= '0;
      rd_vld1_q   <= 1'b0;
      rd_vld2_q   <= 1'b0;
      byp_hit_q   <= 1'b0;
      byp_data_q  <= '0;
      scan_hold_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_ena_q  <= wr_ena_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      rd_vld1_q <= scan_fire;
      rd_vld2_q <= rd_vld1_q;
      if (rd_vld1_q) begin
        byp_hit_q  <= wr_ena_q && (wr_addr_q == rd_addr_q);
        byp_data_q <= wr_data_q;
      end
      if (rd_vld2_q) begin
        scan_hold_q <= scan_result;
      end
    end
  end

endmodule
